// File: rtl/sr_frame_sequencer_if.sv
// Bus bundle between the frame sequencer, the sample front end, the core and the result consumer.
// The master side drives the sequencer inputs (testbench or integration shell); the slave side is the sequencer.
interface sr_frame_sequencer_if #(
  parameter int DW = 14
);
  logic          enable;
  logic          clr_err;
  logic          in_valid;
  logic [DW-1:0] ini;
  logic [DW-1:0] inq;
  logic [DW-1:0] core_ini;
  logic [DW-1:0] core_inq;
  logic          core_start;
  logic          core_valid;
  logic          core_final;
  logic          core_done;
  logic [9:0]    core_arg;
  logic [9:0]    core_mag;
  logic [3:0]    core_class;
  logic [23:0]   core_regres;
  logic          res_valid;
  logic          res_ready;
  logic [9:0]    res_arg;
  logic [9:0]    res_mag;
  logic [3:0]    res_class;
  logic [23:0]   res_regres;
  logic [15:0]   frame_cnt;
  logic          busy;
  logic          overrun;
  logic          timeout_err;
  logic          late_sample;

  modport master (
    output enable, clr_err, in_valid, ini, inq,
    output core_done, core_arg, core_mag, core_class, core_regres, res_ready,
    input  core_ini, core_inq, core_start, core_valid, core_final,
    input  res_valid, res_arg, res_mag, res_class, res_regres,
    input  frame_cnt, busy, overrun, timeout_err, late_sample
  );

  modport slave (
    input  enable, clr_err, in_valid, ini, inq,
    input  core_done, core_arg, core_mag, core_class, core_regres, res_ready,
    output core_ini, core_inq, core_start, core_valid, core_final,
    output res_valid, res_arg, res_mag, res_class, res_regres,
    output frame_cnt, busy, overrun, timeout_err, late_sample
  );
endinterface

// File: rtl/sr_frame_sequencer.sv
// Frames the I/Q stream into N-sample blocks for the core, waits for its result and holds it
// in a one-entry valid/ready register; sticky flags report overrun, timeout and late samples.
module sr_frame_sequencer #(
  parameter int N       = 1000,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 4096,
  parameter int DW      = 14
) (
  input  logic                   clk,
  input  logic                   reset_n,
  sr_frame_sequencer_if.slave    bus
);
  localparam int SW = $clog2(N + 1);
  localparam int GW = $clog2(GAP + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACQ, FLUSH, WAIT_DONE} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] sample_cnt_q, sample_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic [DW-1:0] core_ini_q, core_ini_d, core_inq_q, core_inq_d;
  logic          core_valid_q, core_valid_d, core_final_q, core_final_d;
  logic          res_valid_q, res_valid_d;
  logic [9:0]    res_arg_q, res_arg_d, res_mag_q, res_mag_d;
  logic [3:0]    res_class_q, res_class_d;
  logic [23:0]   res_regres_q, res_regres_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          overrun_q, overrun_d, timeout_q, timeout_d, late_q, late_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      sample_cnt_q <= '0;
      gap_cnt_q    <= '0;
      wait_cnt_q   <= '0;
      core_ini_q   <= '0;
      core_inq_q   <= '0;
      core_valid_q <= 1'b0;
      core_final_q <= 1'b0;
      res_valid_q  <= 1'b0;
      res_arg_q    <= '0;
      res_mag_q    <= '0;
      res_class_q  <= '0;
      res_regres_q <= '0;
      frame_cnt_q  <= '0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
      late_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      core_ini_q   <= core_ini_d;
      core_inq_q   <= core_inq_d;
      core_valid_q <= core_valid_d;
      core_final_q <= core_final_d;
      res_valid_q  <= res_valid_d;
      res_arg_q    <= res_arg_d;
      res_mag_q    <= res_mag_d;
      res_class_q  <= res_class_d;
      res_regres_q <= res_regres_d;
      frame_cnt_q  <= frame_cnt_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
      late_q       <= late_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    core_ini_d   = core_ini_q;
    core_inq_d   = core_inq_q;
    core_valid_d = 1'b0;
    core_final_d = 1'b0;
    res_valid_d  = res_valid_q;
    res_arg_d    = res_arg_q;
    res_mag_d    = res_mag_q;
    res_class_d  = res_class_q;
    res_regres_d = res_regres_q;
    frame_cnt_d  = frame_cnt_q;
    // Clear first so that an error event in the same cycle still sets its flag.
    overrun_d    = bus.clr_err ? 1'b0 : overrun_q;
    timeout_d    = bus.clr_err ? 1'b0 : timeout_q;
    late_d       = bus.clr_err ? 1'b0 : late_q;

    if (res_valid_q && bus.res_ready) res_valid_d = 1'b0;
    if (bus.in_valid && state_q != ACQ) late_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        sample_cnt_d = '0;
        if (bus.enable) state_d = ACQ;
      end
      ACQ: begin
        if (bus.in_valid) begin
          core_valid_d = 1'b1;
          core_ini_d   = bus.ini;
          core_inq_d   = bus.inq;
          if (sample_cnt_q == SW'(N - 1)) begin
            core_final_d = 1'b1;
            sample_cnt_d = '0;
            gap_cnt_d    = '0;
            state_d      = FLUSH;
          end else begin
            sample_cnt_d = sample_cnt_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (gap_cnt_q == GW'(GAP - 1)) begin
          wait_cnt_d = '0;
          state_d    = WAIT_DONE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (bus.core_done) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          // A result accepted downstream this cycle frees the slot for the new one.
          if (!res_valid_q || bus.res_ready) begin
            res_valid_d  = 1'b1;
            res_arg_d    = bus.core_arg;
            res_mag_d    = bus.core_mag;
            res_class_d  = bus.core_class;
            res_regres_d = bus.core_regres;
          end else begin
            overrun_d = 1'b1;
          end
          state_d = bus.enable ? ACQ : IDLE;
        end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = bus.enable ? ACQ : IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.core_ini    = core_ini_q;
  assign bus.core_inq    = core_inq_q;
  assign bus.core_valid  = core_valid_q;
  assign bus.core_final  = core_final_q;
  assign bus.core_start  = (state_q == ACQ);
  assign bus.busy        = (state_q != IDLE);
  assign bus.res_valid   = res_valid_q;
  assign bus.res_arg     = res_arg_q;
  assign bus.res_mag     = res_mag_q;
  assign bus.res_class   = res_class_q;
  assign bus.res_regres  = res_regres_q;
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.overrun     = overrun_q;
  assign bus.timeout_err = timeout_q;
  assign bus.late_sample = late_q;
endmodule
